// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave register file with NUM_REGS 32-bit read/write registers.
// AW and W are accepted independently, in either order. Only one write and
// one read are outstanding at a time. Register contents and per-register
// write pulses are exported to user logic.
module axi_lite_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse
);
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NBYTES = DW / 8;

    typedef enum logic {W_COLLECT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_VALID} rstate_t;

    wstate_t              r_wstate, w_wstate_nxt;
    rstate_t              r_rstate, w_rstate_nxt;

    logic [DW-1:0]        r_regs [NUM_REGS];
    logic                 r_aw_cap, r_w_cap;
    logic [IDX_W-1:0]     r_awidx;
    logic [DW-1:0]        r_wdata;
    logic [NBYTES-1:0]    r_wstrb;
    logic [1:0]           r_bresp;
    logic [DW-1:0]        r_rdata;
    logic [1:0]           r_rresp;
    logic [NUM_REGS-1:0]  r_pulse;

    logic                 w_awready, w_wready, w_bvalid, w_commit;
    logic                 w_arready, w_rvalid;
    logic [IDX_W-1:0]     w_cidx, w_ridx;
    logic [DW-1:0]        w_cdata, w_rsel_data;
    logic [NBYTES-1:0]    w_cstrb;
    logic [NUM_REGS-1:0]  w_wsel, w_rsel;
    logic                 w_wok, w_rok;
    logic                 w_unused;

    // Protection bits and the byte offset within a word carry no meaning here.
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Commit operands come from the latched copy if that channel arrived earlier,
    // otherwise straight from the bus in the handshake cycle.
    assign w_cidx  = r_aw_cap ? r_awidx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_cdata = r_w_cap  ? r_wdata : S_AXI_WDATA;
    assign w_cstrb = r_w_cap  ? r_wstrb : S_AXI_WSTRB;
    assign w_ridx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    // Address decode: one-hot selects for write and read, empty when out of range.
    always_comb begin
        w_wsel      = '0;
        w_rsel      = '0;
        w_rsel_data = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            w_wsel[k] = (w_cidx == IDX_W'(k));
            w_rsel[k] = (w_ridx == IDX_W'(k));
            if (w_rsel[k]) w_rsel_data = r_regs[k];
        end
        w_wok = |w_wsel;
        w_rok = |w_rsel;
    end

    // Write FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_wstate <= W_COLLECT;
        else          r_wstate <= w_wstate_nxt;
    end

    // Write FSM next state, channel readiness and commit decision.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        w_commit     = 1'b0;
        case (r_wstate)
            W_COLLECT: begin
                w_awready = !r_aw_cap;
                w_wready  = !r_w_cap;
                if ((r_aw_cap || S_AXI_AWVALID) && (r_w_cap || S_AXI_WVALID)) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (S_AXI_BREADY) w_wstate_nxt = W_COLLECT;
            end
            default: w_wstate_nxt = W_COLLECT;
        endcase
    end

    // Capture AW/W independently; flags stay set until the B handshake.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_aw_cap <= 1'b0;
            r_w_cap  <= 1'b0;
            r_awidx  <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else if (w_bvalid && S_AXI_BREADY) begin
            r_aw_cap <= 1'b0;
            r_w_cap  <= 1'b0;
        end else begin
            if (w_awready && S_AXI_AWVALID) begin
                r_aw_cap <= 1'b1;
                r_awidx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_wready && S_AXI_WVALID) begin
                r_w_cap <= 1'b1;
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
        end
    end

    // Register array: byte-lane update on commit, response code and write pulse.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
            r_bresp <= 2'b00;
            r_pulse <= '0;
        end else begin
            r_pulse <= w_commit ? w_wsel : '0;
            if (w_commit) begin
                r_bresp <= w_wok ? 2'b00 : 2'b10;
                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                    for (int unsigned b = 0; b < NBYTES; b++) begin
                        if (w_wsel[k] && w_cstrb[b]) r_regs[k][8*b +: 8] <= w_cdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_rstate <= R_IDLE;
        else          r_rstate <= w_rstate_nxt;
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_rvalid     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (S_AXI_ARVALID) w_rstate_nxt = R_VALID;
            end
            R_VALID: begin
                w_rvalid = 1'b1;
                if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read data is sampled at AR acceptance, so a same-cycle write is not seen.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rdata <= '0;
            r_rresp <= 2'b00;
        end else if (w_arready && S_AXI_ARVALID) begin
            r_rdata <= w_rok ? w_rsel_data : '0;
            r_rresp <= w_rok ? 2'b00 : 2'b10;
        end
    end

    // Flatten the register array for user logic.
    always_comb begin
        reg_out = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) reg_out[DW*k +: DW] = r_regs[k];
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = w_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = w_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign reg_wr_pulse  = r_pulse;

endmodule
